imem_fetch: RTL and testbench

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_fetch.sv | 127 ++++++++++++
 tb/tb_imem_fetch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Instruction fetch unit: turns a PC-stage fetch strobe into a single bus read,
// with a bounded bus wait, flush abort and misalignment detection.
module imem_fetch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [31:0] i_address,
  input  logic        flush,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        mem_rd_q, mem_rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  // Set on every exit from WAIT: the first IDLE cycle afterwards is a bubble
  // in which fetch_req is not sampled.
  logic        holdoff_q, holdoff_d;

  // NOTE: every variable gets its default before the case statement, so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    holdoff_d  = holdoff_q;

    unique case (state_q)
      IDLE: begin
        if (holdoff_q) begin
          holdoff_d = 1'b0;
        end else if (fetch_req && !flush) begin
          if (i_address[1:0] == 2'b00) begin
            mem_addr_d = i_address;
            mem_rd_d   = 1'b1;
            cnt_d      = 8'd0;
            state_d    = WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      WAIT: begin
        // Flush dominates a same-cycle ready; ready dominates the timeout.
        if (flush) begin
          mem_rd_d  = 1'b0;
          cnt_d     = 8'd0;
          holdoff_d = 1'b1;
          state_d   = IDLE;
        end else if (mem_ready) begin
          instr_d   = mem_rdata;
          valid_d   = 1'b1;
          mem_rd_d  = 1'b0;
          cnt_d     = 8'd0;
          holdoff_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          err_d     = 1'b1;
          mem_rd_d  = 1'b0;
          cnt_d     = 8'd0;
          holdoff_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      holdoff_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      holdoff_q  <= holdoff_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
  assign busy        = (state_q == WAIT);

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: expected instr_valid / fetch_err events are
// queued when stimulus is driven and retired by a monitor as the DUT emits them.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req;
  logic [31:0] i_address;
  logic        flush;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  imem_fetch #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .i_address   (i_address),
    .flush       (flush),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input bit is_err, input logic [31:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && (instr_valid === 1'b1 || fetch_err === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_event", {30'd0, instr_valid, fetch_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_not_both", {31'd0, instr_valid & fetch_err}, 32'd0);
        chk("sb_event_kind", {31'd0, fetch_err}, {31'd0, e.is_err});
        if (!e.is_err) chk("sb_instr", instr, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd_cycles;
    int run;
    int rises;
    int last_rise;
    logic prev_rd;

    reset_n   = 1'b0;
    fetch_req = 1'b0;
    i_address = '0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_flags", {29'd0, instr_valid, busy, fetch_err}, 32'd0);

    // Release reset and request on the very first active edge; zero-wait bus
    reset_n   = 1'b1;
    fetch_req = 1'b1;
    i_address = 32'h0000_0040;
    cyc();
    fetch_req = 1'b0;
    chk("f0_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("f0_mem_addr", mem_addr, 32'h0000_0040);
    chk("f0_busy", {31'd0, busy}, 32'd1);
    chk("f0_not_valid_yet", {31'd0, instr_valid}, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h2001_0005;
    push(1'b0, 32'h2001_0005);
    cyc();
    mem_ready = 1'b0;
    chk("f0_valid", {31'd0, instr_valid}, 32'd1);
    chk("f0_instr", instr, 32'h2001_0005);
    chk("f0_rd_cleared", {31'd0, mem_rd}, 32'd0);
    cyc();
    chk("f0_valid_one_cycle", {31'd0, instr_valid}, 32'd0);

    // mem_ready while idle is ignored
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_1111;
    cyc(); cyc();
    chk("idle_ready_ignored", {30'd0, instr_valid, mem_rd}, 32'd0);
    chk("idle_ready_instr", instr, 32'h2001_0005);
    mem_ready = 1'b0;

    // Misaligned request
    fetch_req = 1'b1;
    i_address = 32'h0000_0102;
    push(1'b1, 32'h0);
    cyc();
    fetch_req = 1'b0;
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_no_rd", {30'd0, mem_rd, busy}, 32'd0);
    chk("mis_instr_kept", instr, 32'h2001_0005);
    cyc();
    chk("mis_err_one_cycle", {30'd0, fetch_err, mem_rd}, 32'd0);

    // Bus timeout with ready held low
    fetch_req = 1'b1;
    i_address = 32'h0000_0080;
    push(1'b1, 32'h0);
    rd_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      fetch_req = 1'b0;
      if (mem_rd === 1'b1) rd_cycles++;
      else break;
    end
    chk("to_rd_cycles", rd_cycles, 32'd16);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_instr_kept", instr, 32'h2001_0005);
    cyc();

    // Ready on the final allowed cycle succeeds; fetch_req during WAIT ignored
    fetch_req = 1'b1;
    i_address = 32'h0000_0080;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      fetch_req = (i == 5);
      i_address = (i == 5) ? 32'h0000_0500 : 32'h0000_0080;
      chk("lr_rd_high", {31'd0, mem_rd}, 32'd1);
      if (i == 16) begin
        chk("lr_addr_stable", mem_addr, 32'h0000_0080);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_0016;
        push(1'b0, 32'hCAFE_0016);
      end
    end
    cyc();
    mem_ready = 1'b0;
    chk("lr_valid", {31'd0, instr_valid}, 32'd1);
    chk("lr_no_err", {31'd0, fetch_err}, 32'd0);
    chk("lr_instr", instr, 32'hCAFE_0016);
    cyc(); cyc();
    chk("lr_no_queued_req", {30'd0, mem_rd, busy}, 32'd0);

    // Flush in WAIT beats a same-cycle ready
    fetch_req = 1'b1;
    i_address = 32'h0000_0100;
    cyc();
    fetch_req = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd1);
    flush     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    cyc();
    flush     = 1'b0;
    mem_ready = 1'b0;
    chk("fl_rd_cleared", {30'd0, mem_rd, busy}, 32'd0);
    chk("fl_no_events", {30'd0, instr_valid, fetch_err}, 32'd0);
    chk("fl_instr_kept", instr, 32'hCAFE_0016);
    cyc(); cyc();

    // Flush and fetch_req together in IDLE: request dropped
    fetch_req = 1'b1;
    flush     = 1'b1;
    i_address = 32'h0000_0200;
    cyc();
    fetch_req = 1'b0;
    flush     = 1'b0;
    chk("flreq_dropped", {30'd0, mem_rd, busy}, 32'd0);
    cyc();

    // Asynchronous reset after three wait cycles
    fetch_req = 1'b1;
    i_address = 32'h0000_0300;
    cyc();
    fetch_req = 1'b0;
    cyc(); cyc(); cyc();
    chk("rw_busy_before", {31'd0, busy}, 32'd1);
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    #1;
    chk("rw_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rw_mem_addr", mem_addr, 32'd0);
    chk("rw_instr", instr, 32'd0);
    chk("rw_flags", {29'd0, instr_valid, busy, fetch_err}, 32'd0);
    cyc();
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    fetch_req = 1'b1;
    i_address = 32'h0000_0000;
    cyc();
    fetch_req = 1'b0;
    chk("rw_refetch_rd", {31'd0, mem_rd}, 32'd1);
    chk("rw_refetch_addr", mem_addr, 32'h0000_0000);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0013;
    push(1'b0, 32'h0000_0013);
    cyc();
    mem_ready = 1'b0;
    chk("rw_refetch_valid", {31'd0, instr_valid}, 32'd1);
    cyc(); cyc();

    // fetch_req held high against a one-wait memory
    fetch_req = 1'b1;
    i_address = 32'h0000_0400;
    run       = 0;
    rises     = 0;
    last_rise = 0;
    prev_rd   = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (mem_rd === 1'b1) begin
        run++;
        if (!prev_rd) begin
          if (rises > 0) chk("hold_req_spacing", k - last_rise, 32'd4);
          rises++;
          last_rise = k;
        end
      end else begin
        run = 0;
      end
      prev_rd   = mem_rd;
      mem_ready = (mem_rd === 1'b1) && (run == 2);
      mem_rdata = 32'h0000_1000 + 32'(k);
      if (mem_ready) push(1'b0, 32'h0000_1000 + 32'(k));
    end
    chk("hold_req_count", rises, 32'd4);
    fetch_req = 1'b0;
    cyc();
    mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) cyc();
    chk("hold_req_idle", {30'd0, mem_rd, busy}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
